// File: rtl/vga_image_pkg.sv
// Shared widths, pixel-format selection and FSM states
// for the VGA image buffer write path.
package vga_image_pkg;

  localparam int X_BITS   = 9;
  localparam int Y_BITS   = 7;
  localparam int A_BITS   = X_BITS + Y_BITS;
  localparam int W_BITS   = X_BITS + 1;
  localparam int H_BITS   = Y_BITS + 1;
  localparam int REM_BITS = A_BITS + 1;

`ifdef VGA_8BIT_IMAGE
  localparam int PWIDTH = 8;
`else
  localparam int PWIDTH = 12;
`endif

  localparam int PIX_PER_WORD = (PWIDTH == 8) ? 4 : 2;
  localparam int LANE_W       = 32 / PIX_PER_WORD;
  localparam int LANE_BITS    = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/vga_word_unpack.sv
// Holds one packed pixel word and hands out its lanes,
// lane 0 first, one per take.
module vga_word_unpack
  import vga_image_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              more,
  input  logic              take,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              pix_valid,
  output logic [PWIDTH-1:0] pix
);

  logic [31:0]          word;
  logic [LANE_BITS-1:0] lane;
  logic                 full;
  logic                 last_lane;

  assign last_lane = lane == LANE_BITS'(PIX_PER_WORD - 1);
  assign pix_valid = full;
  assign pix       = word[int'(lane) * LANE_W +: PWIDTH];

  // Refill in the same cycle the last lane drains keeps 1 pixel/cycle.
  assign in_ready = en & (~full | (take & last_lane & more));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word <= '0;
      lane <= '0;
      full <= 1'b0;
    end else if (flush) begin
      lane <= '0;
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      word <= in_data;
      lane <= '0;
      full <= 1'b1;
    end else if (take) begin
      if (last_lane) begin
        lane <= '0;
        full <= 1'b0;
      end else begin
        lane <= lane + LANE_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/vga_image_writer.sv
// Fills a programmed rectangle of the image buffer from a
// packed pixel stream; address leads image_we by one cycle.
module vga_image_writer
  import vga_image_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [8:0]        cfg_x0,
  input  logic [6:0]        cfg_y0,
  input  logic [9:0]        cfg_w,
  input  logic [7:0]        cfg_h,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              image_we,
  output logic [15:0]       address,
  output logic [PWIDTH-1:0] image_data,
  output logic              busy,
  output logic              done
);

  state_e state, state_n;

  logic [X_BITS-1:0]   x0_q;
  logic [W_BITS-1:0]   w_q;
  logic [W_BITS-1:0]   col_cnt;
  logic [REM_BITS-1:0] remaining;
  logic [W_BITS-1:0]   w_eff;
  logic [H_BITS-1:0]   h_eff;
  logic [X_BITS-1:0]   nxt_col;
  logic [Y_BITS-1:0]   nxt_row;
  logic                row_end;
  logic                more;
  logic                take;
  logic                flush;
  logic                unpack_en;
  logic                pix_valid;
  logic [PWIDTH-1:0]   pix;

  assign w_eff = (cfg_w == '0) ? W_BITS'(1 << X_BITS) : cfg_w;
  assign h_eff = (cfg_h == '0) ? H_BITS'(1 << Y_BITS) : cfg_h;
  assign more  = remaining > REM_BITS'(1);

  // Columns wrap inside the row; only a full row moves to the next one.
  assign row_end = col_cnt == w_q - W_BITS'(1);
  assign nxt_col = row_end ? x0_q
                 : address[X_BITS-1:0] + X_BITS'(1);
  assign nxt_row = row_end ? address[A_BITS-1:X_BITS] + Y_BITS'(1)
                 : address[A_BITS-1:X_BITS];

  vga_word_unpack u_unpack (
    .clk       (clk),
    .resetn    (resetn),
    .en        (unpack_en),
    .more      (more),
    .take      (take),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .pix_valid (pix_valid),
    .pix       (pix)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b1;
    done      = 1'b0;
    take      = 1'b0;
    flush     = 1'b0;
    unpack_en = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_n = PRIME;
      end
      PRIME: begin
        unpack_en = 1'b1;
        state_n   = WRITE;
      end
      WRITE: begin
        if (remaining == '0) begin
          flush   = 1'b1;
          state_n = DONE;
        end else begin
          unpack_en = 1'b1;
          take      = pix_valid;
        end
      end
      DONE: begin
        done    = 1'b1;
        flush   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      image_we   <= 1'b0;
      address    <= '0;
      image_data <= '0;
      x0_q       <= '0;
      w_q        <= '0;
      col_cnt    <= '0;
      remaining  <= '0;
    end else begin
      image_we <= take;
      if (take) begin
        image_data <= pix;
        address    <= {nxt_row, nxt_col};
        col_cnt    <= row_end ? '0 : col_cnt + W_BITS'(1);
        remaining  <= remaining - REM_BITS'(1);
      end else if (state == IDLE && start) begin
        x0_q      <= cfg_x0;
        w_q       <= w_eff;
        col_cnt   <= '0;
        address   <= {cfg_y0, cfg_x0};
        remaining <= REM_BITS'(w_eff) * REM_BITS'(h_eff);
      end
    end
  end

endmodule

// File: tb/tb_vga_image_writer.sv
// Directed bench for vga_image_writer: table vectors plus
// stall, wrap, early-end, reset and full-frame sequences.
module tb_vga_image_writer;
  import vga_image_pkg::*;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [8:0]        cfg_x0 = '0;
  logic [6:0]        cfg_y0 = '0;
  logic [9:0]        cfg_w = '0;
  logic [7:0]        cfg_h = '0;
  logic              in_valid = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_ready;
  logic              image_we;
  logic [15:0]       address;
  logic [PWIDTH-1:0] image_data;
  logic              busy;
  logic              done;

  int nvec = 0;
  int nerr = 0;

  vga_image_writer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .cfg_x0     (cfg_x0),
    .cfg_y0     (cfg_y0),
    .cfg_w      (cfg_w),
    .cfg_h      (cfg_h),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .image_we   (image_we),
    .address    (address),
    .image_data (image_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [15:0]       wq_a[$];
  logic [PWIDTH-1:0] wq_d[$];
  int   done_cnt, hold_bad, acc_cnt, cyc, done_cyc, fall_cyc;
  logic busy_at_done;
  logic [15:0] prev_addr = '0;
  logic prev_busy = 1'b0;

  // Each write is logged with the address shown one cycle earlier.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (image_we) begin
      wq_a.push_back(prev_addr);
      wq_d.push_back(image_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    if (prev_busy && !busy) fall_cyc = cyc;
    if (prev_busy && busy && !image_we && address != prev_addr)
      hold_bad++;
    if (in_valid && in_ready) acc_cnt++;
    prev_addr = address;
    prev_busy = busy;
  end

  typedef struct {
    logic [31:0] word;
    logic [15:0] a0, a1;
    logic [11:0] d0, d1;
  } vec_t;

  vec_t tv[4];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: timeout got 1 expected 0", name);
  endtask

  function automatic logic [11:0] pix(input int p);
    return 12'(p * 37 + 5);
  endfunction

  function automatic logic [31:0] mkword(input int k);
    return {4'hF, pix(2 * k + 1), 4'hA, pix(2 * k)};
  endfunction

  task automatic clear();
    wq_a.delete();
    wq_d.delete();
    done_cnt = 0;
    hold_bad = 0;
    acc_cnt  = 0;
    done_cyc = -1;
    fall_cyc = -1;
  endtask

  task automatic kick(input int x0, input int y0,
                      input int w, input int h);
    @(negedge clk);
    cfg_x0 = 9'(x0);
    cfg_y0 = 7'(y0);
    cfg_w  = 10'(w);
    cfg_h  = 8'(h);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout("send");
    else @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) timeout("wait_done");
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic run_table(input int gap, input string tag);
    clear();
    kick(0, 0, 4, 2);
    for (int i = 0; i < 4; i++) begin
      send(tv[i].word);
      repeat (gap) @(negedge clk);
    end
    wait_done(100);
    check({tag, "_nwrites"}, wq_a.size(), 8);
    for (int i = 0; i < 4; i++) begin
      if (wq_a.size() >= 2 * i + 2) begin
        check({tag, "_a0"}, wq_a[2*i], tv[i].a0);
        check({tag, "_d0"}, wq_d[2*i], tv[i].d0);
        check({tag, "_a1"}, wq_a[2*i+1], tv[i].a1);
        check({tag, "_d1"}, wq_d[2*i+1], tv[i].d1);
      end
    end
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_words"}, acc_cnt, 4);
  endtask

  initial begin
    logic [15:0] wrap_a[4];
    int bad;

    tv[0] = '{32'h0ABC_0123, 16'h0000, 16'h0001, 12'h123, 12'hABC};
    tv[1] = '{32'h0DEF_0456, 16'h0002, 16'h0003, 12'h456, 12'hDEF};
    tv[2] = '{32'h0222_0111, 16'h0200, 16'h0201, 12'h111, 12'h222};
    tv[3] = '{32'h0444_0333, 16'h0202, 16'h0203, 12'h333, 12'h444};
    wrap_a = '{16'h07FE, 16'h07FF, 16'h0600, 16'h0601};

    #12;
    check("rst_we", image_we, 0);
    check("rst_addr", address, 0);
    check("rst_data", image_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_ready, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run_table(0, "t1");
    run_table(3, "gap");

    clear();
    kick(510, 3, 4, 1);
    send(mkword(0));
    send(mkword(1));
    wait_done(100);
    check("wrap_n", wq_a.size(), 4);
    for (int p = 0; p < 4; p++) begin
      if (p < wq_a.size()) begin
        check("wrap_a", wq_a[p], wrap_a[p]);
        check("wrap_d", wq_d[p], pix(p));
      end
    end
    check("wrap_done", done_cnt, 1);

    clear();
    kick(20, 9, 3, 1);
    send(mkword(0));
    send(mkword(1));
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = mkword(2);
    wait_done(100);
    check("short_n", wq_a.size(), 3);
    for (int p = 0; p < 3; p++) begin
      if (p < wq_a.size()) begin
        check("short_a", wq_a[p], {7'd9, 9'(20 + p)});
        check("short_d", wq_d[p], pix(p));
      end
    end
    check("short_acc", acc_cnt, 2);
    check("short_ready", in_ready, 0);
    check("short_busy_done", busy_at_done, 1);
    check("short_fall", fall_cyc, done_cyc + 1);
    in_valid = 1'b0;

    clear();
    kick(0, 0, 4, 2);
    for (int i = 0; i < 3; i++) send(tv[i].word);
    begin
      int n = 0;
      while (wq_a.size() < 5 && n < 50) begin
        @(negedge clk);
        #2;
        n++;
      end
      if (n >= 50) timeout("rst_wait");
    end
    resetn = 1'b0;
    #1;
    check("mid_we", image_we, 0);
    check("mid_addr", address, 0);
    check("mid_data", image_data, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    #2;
    check("mid_nwrites", wq_a.size(), 5);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_table(0, "after_rst");

    clear();
    kick(0, 0, 0, 0);
    for (int k = 0; k < 32768; k++) begin
      if (k == 1000) begin
        start  = 1'b1;
        cfg_x0 = 9'd7;
        cfg_w  = 10'd3;
      end
      if (k == 1001) start = 1'b0;
      send(mkword(k));
    end
    wait_done(50);
    check("frame_n", wq_a.size(), 65536);
    bad = 0;
    for (int p = 0; p < wq_a.size(); p++)
      if (wq_a[p] != 16'(p) || wq_d[p] != pix(p)) bad++;
    check("frame_data", bad, 0);
    if (wq_a.size() > 0)
      check("frame_last", wq_a[wq_a.size()-1], 16'hFFFF);
    check("frame_done", done_cnt, 1);
    check("frame_hold", hold_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
